// File: rtl/mnist_1to256pix.sv
// 28x28 frame capture buffer replayed as a (IMG_DIM<<SCALE_LOG2)^2 pixel-replicated raster stream.
// Optional MNIST_BINARIZE_EN: output pixels thresholded against BIN_THRESH to 0x00/0xFF.
module mnist_1to256pix #(
  parameter int unsigned IMG_DIM    = 28,
  parameter int unsigned SCALE_LOG2 = 4,
  parameter int unsigned BIN_THRESH = 128
) (
  input  logic       cmos_pclk,
  input  logic       rst_n,
  input  logic       mnist_start,
  input  logic       mnist_data_valid_norm,
  input  logic [7:0] mnist_data_norm,
  output logic       frame_ready,
  input  logic       disp_start,
  input  logic       disp_ready,
  output logic       disp_valid,
  output logic [7:0] disp_data,
  output logic [8:0] disp_h,
  output logic [8:0] disp_v,
  output logic       disp_last,
  output logic       busy
);

  localparam int unsigned NPIX    = IMG_DIM * IMG_DIM;
  localparam int unsigned OUT_DIM = IMG_DIM << SCALE_LOG2;
  localparam int unsigned AW      = 10;
  localparam int unsigned CW      = 9;
  localparam logic [CW-1:0] OUT_MAX = CW'(OUT_DIM - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_STREAM
  } state_e;

  // ---------------- write side ----------------
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          frame_ready_q, frame_ready_d;
  logic          wr_en_c;
  logic [7:0]    mem_q [NPIX];

  // A start pulse wins over a same-cycle strobe
  assign wr_en_c = !mnist_start && mnist_data_valid_norm && (wr_cnt_q < AW'(NPIX));

  always_comb begin
    wr_cnt_d      = wr_cnt_q;
    frame_ready_d = frame_ready_q;
    if (mnist_start) begin
      wr_cnt_d      = '0;
      frame_ready_d = 1'b0;
    end else if (wr_en_c) begin
      wr_cnt_d = wr_cnt_q + AW'(1);
      if (wr_cnt_q == AW'(NPIX - 1)) frame_ready_d = 1'b1;
    end
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q      <= '0;
      frame_ready_q <= 1'b0;
    end else begin
      wr_cnt_q      <= wr_cnt_d;
      frame_ready_q <= frame_ready_d;
    end
  end

  always_ff @(posedge cmos_pclk) begin
    if (wr_en_c) mem_q[wr_cnt_q] <= mnist_data_norm;
  end

  // ---------------- read side ----------------
  state_e        state_q, state_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          valid_q, valid_d, last_q, last_d, busy_q, busy_d;
  logic [7:0]    data_q, data_d;
  logic          fire_c, rd_en_c;
  logic [AW-1:0] rd_addr_c;
  logic [7:0]    rd_val_c;

  // Address follows the post-fire coordinate so data always tracks (h,v) without bubbles
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    rd_en_c = 1'b0;
    fire_c  = valid_q && disp_ready;
    case (state_q)
      ST_IDLE: begin
        if (disp_start && frame_ready_q) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        h_d     = '0;
        v_d     = '0;
        rd_en_c = 1'b1;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        rd_en_c = 1'b1;
        if (fire_c) begin
          if (last_q) begin
            state_d = ST_IDLE;
            h_d     = '0;
            v_d     = '0;
            rd_en_c = 1'b0;
          end else if (h_q == OUT_MAX) begin
            h_d = '0;
            v_d = v_q + CW'(1);
          end else begin
            h_d = h_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rd_addr_c = AW'(((v_d >> SCALE_LOG2) * IMG_DIM) + (h_d >> SCALE_LOG2));
`ifdef MNIST_BINARIZE_EN
    rd_val_c = ({1'b0, mem_q[rd_addr_c]} >= 9'(BIN_THRESH)) ? 8'hFF : 8'h00;
`else
    rd_val_c = mem_q[rd_addr_c];
`endif
    data_d  = rd_en_c ? rd_val_c : data_q;
    valid_d = (state_d == ST_STREAM);
    last_d  = valid_d && (h_d == OUT_MAX) && (v_d == OUT_MAX);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
    end
  end

  assign frame_ready = frame_ready_q;
  assign disp_valid  = valid_q;
  assign disp_data   = data_q;
  assign disp_h      = h_q;
  assign disp_v      = v_q;
  assign disp_last   = last_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mnist_1to256pix.sv
// Scoreboard bench for mnist_1to256pix; runs a reduced replication factor so full frames fit the cycle budget.
module tb_mnist_1to256pix;

  localparam int unsigned IMG  = 28;
  localparam int unsigned SL2  = 2;
  localparam int unsigned OUT  = IMG << SL2;
  localparam int unsigned NPIX = IMG * IMG;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       mnist_start = 1'b0;
  logic       mnist_data_valid_norm = 1'b0;
  logic [7:0] mnist_data_norm = '0;
  logic       frame_ready;
  logic       disp_start = 1'b0;
  logic       disp_ready = 1'b0;
  logic       disp_valid;
  logic [7:0] disp_data;
  logic [8:0] disp_h;
  logic [8:0] disp_v;
  logic       disp_last;
  logic       busy;

  mnist_1to256pix #(
    .IMG_DIM   (IMG),
    .SCALE_LOG2(SL2),
    .BIN_THRESH(128)
  ) dut (
    .cmos_pclk            (clk),
    .rst_n                (rst_n),
    .mnist_start          (mnist_start),
    .mnist_data_valid_norm(mnist_data_valid_norm),
    .mnist_data_norm      (mnist_data_norm),
    .frame_ready          (frame_ready),
    .disp_start           (disp_start),
    .disp_ready           (disp_ready),
    .disp_valid           (disp_valid),
    .disp_data            (disp_data),
    .disp_h               (disp_h),
    .disp_v               (disp_v),
    .disp_last            (disp_last),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0]  model_mem [NPIX];
  logic [26:0] exp_q [$];  // {last, v, h, data}

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_val(input int h, input int v);
    int idx;
    logic [7:0] val;
    idx = IMG * (v >> SL2) + (h >> SL2);
    val = model_mem[idx];
`ifdef MNIST_BINARIZE_EN
    val = (val >= 8'd128) ? 8'hFF : 8'h00;
`endif
    return val;
  endfunction

  task automatic push_frame();
    for (int v = 0; v < OUT; v++)
      for (int h = 0; h < OUT; h++)
        exp_q.push_back({(h == OUT - 1) && (v == OUT - 1), 9'(v), 9'(h), exp_val(h, v)});
  endtask

  task automatic write_frame(input bit use_index, input bit gap);
    for (int i = 0; i < NPIX; i++) begin
      model_mem[i] = use_index ? 8'(i) : 8'h11;
      if (i == NPIX - 1) begin
        chk("fr_before_last_wr", 32'(frame_ready), 32'd0);
        disp_start = 1'b1;
      end
      mnist_data_valid_norm = 1'b1;
      mnist_data_norm       = model_mem[i];
      tick();
      mnist_data_valid_norm = 1'b0;
      disp_start            = 1'b0;
      if (i == NPIX - 1) chk("fr_after_last_wr", 32'(frame_ready), 32'd1);
      if (gap) tick();
    end
    tick();
    chk("start_with_last_wr_ignored", 32'(busy), 32'd0);
  endtask

  // Each cycle the outputs must equal the queue head; it is popped only when the fire happens
  task automatic run_stream(input bit rand_rdy, input bit abort);
    int fires = 0;
    int cyc   = 0;
    logic [26:0] e;
    disp_start = 1'b1;
    disp_ready = 1'b1;
    push_frame();
    tick();
    disp_start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("valid_not_yet", 32'(disp_valid), 32'd0);
    tick();
    chk("valid_after_start", 32'(disp_valid), 32'd1);
    while (exp_q.size() > 0 && cyc < 40000) begin
      e = exp_q[0];
      chk("pix", {4'd0, disp_valid, disp_last, disp_v, disp_h, disp_data}, {4'd0, 1'b1, e});
      if (abort && e[25:17] == 9'd60 && e[16:8] == 9'd50) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", {3'd0, disp_valid, disp_data, disp_h, disp_v, disp_last, busy},
            32'd0);
        chk("rst_mid_frame_ready", 32'(frame_ready), 32'd0);
        exp_q.delete();
        break;
      end
      disp_start = (cyc == 100);
      disp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (disp_ready) begin
        void'(exp_q.pop_front());
        fires++;
      end
      tick();
      cyc++;
    end
    disp_start = 1'b0;
    if (!abort) begin
      chk("stream_timeout", 32'(exp_q.size()), 32'd0);
      chk("fire_count", 32'(fires), 32'(OUT * OUT));
      chk("end_outs", {29'd0, disp_valid, disp_last, busy}, 32'd0);
      disp_ready = 1'b1;
    end
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outs", {3'd0, disp_valid, disp_data, disp_h, disp_v, disp_last, busy}, 32'd0);
    chk("reset_frame_ready", 32'(frame_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Start with no captured frame must be ignored
    disp_start = 1'b1;
    tick();
    disp_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("nofr_valid", 32'(disp_valid), 32'd0);
      chk("nofr_busy", 32'(busy), 32'd0);
      tick();
    end

    write_frame(1'b1, 1'b1);
    run_stream(1'b0, 1'b0);
    run_stream(1'b1, 1'b0);
    chk("frame_ready_kept", 32'(frame_ready), 32'd1);

    // Start wins over a same-cycle strobe, then refill with 0x11
    mnist_start           = 1'b1;
    mnist_data_valid_norm = 1'b1;
    mnist_data_norm       = 8'hAA;
    tick();
    mnist_start           = 1'b0;
    mnist_data_valid_norm = 1'b0;
    chk("fr_cleared_by_start", 32'(frame_ready), 32'd0);
    write_frame(1'b0, 1'b0);
    mnist_data_valid_norm = 1'b1;
    mnist_data_norm       = 8'h77;
    tick();
    mnist_data_valid_norm = 1'b0;
    tick();
    chk("fr_after_extra_wr", 32'(frame_ready), 32'd1);
    run_stream(1'b0, 1'b1);

    #3;
    rst_n = 1'b1;
    tick();
    disp_start = 1'b1;
    tick();
    disp_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_valid", 32'(disp_valid), 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mnist_1to256pix.md
# mnist_1to256pix

Expands a 28x28 8-bit MNIST image back into a 448x448 raster stream by 16x16 pixel replication, for display overlay of the normalized digit. It sits after the 256-to-1 downsampler. It captures the 784-byte normalized frame into an internal buffer, then streams it out on a valid/ready display interface on request.

## Interface

Parameters:
- IMG_DIM, 28, source image side length in pixels.
- SCALE_LOG2, 4, replication factor log2. The output side is IMG_DIM << SCALE_LOG2, which is 448.
- BIN_THRESH, 128, threshold used only when MNIST_BINARIZE_EN is defined.

Ports:
- cmos_pclk  in  1  pixel clock; all logic runs on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mnist_start  in  1  single-cycle pulse that begins a new capture frame.
- mnist_data_valid_norm  in  1  write strobe for one normalized pixel.
- mnist_data_norm  in  8  normalized pixel, raster order, row-major.
- frame_ready  out  1  high once 784 pixels have been captured.
- disp_start  in  1  single-cycle request to stream the buffered frame.
- disp_ready  in  1  downstream accept.
- disp_valid  out  1  output pixel valid.
- disp_data  out  8  output pixel value.
- disp_h  out  9  output column, 0..447.
- disp_v  out  9  output row, 0..447.
- disp_last  out  1  high with the pixel at (447,447).
- busy  out  1  high while the read FSM is not IDLE.

## Operation

Write side:
- The write counter wr_cnt is 10 bits wide.
- mnist_start clears wr_cnt and frame_ready.
- If mnist_start and mnist_data_valid_norm are high in the same cycle, start wins and that data is dropped.
- When mnist_data_valid_norm is high and wr_cnt < 784, the block writes buf[wr_cnt] and increments wr_cnt.
- On the write that makes wr_cnt 784, frame_ready is set on the next edge.
- Strobes received while wr_cnt == 784 are ignored.

Buffer:
- 784 x 8 storage with a registered read port (1-cycle latency). It may infer block RAM or distributed RAM.

Read FSM:
- IDLE:
  - disp_start with frame_ready high moves to FETCH.
  - disp_start with frame_ready low is ignored.
- FETCH: issues a read of address 0 with h=v=0, then moves to STREAM.
- STREAM:
  - disp_valid is high.
  - A fire is disp_valid && disp_ready. On a fire, (h,v) advance raster-wise: h wraps 447→0 and increments v.
  - A fire on disp_last returns the FSM to IDLE.
  - disp_start received while in STREAM or FETCH is ignored.
- Read address = IMG_DIM*(v_next>>SCALE_LOG2) + (h_next>>SCALE_LOG2), where (h_next,v_next) is the coordinate after a fire, or the current coordinate when there is no fire. disp_data therefore always matches disp_h/disp_v, with no bubbles.
- A stall (disp_ready low) holds disp_data, disp_h, disp_v and disp_last stable.
- The buffer is not cleared after readout. frame_ready stays high, so the same frame can be streamed repeatedly.
- mnist_start during STREAM does not abort the stream. Pixels overwritten mid-stream appear in the output. Upstream sequencing must prevent this.

## Timing

Reset values:
- frame_ready=0, disp_valid=0, disp_data=0, disp_h=0, disp_v=0, disp_last=0, busy=0.
- FSM is in IDLE; wr_cnt=0.

Latencies:
- disp_start accepted at edge N: busy=1 after N, disp_valid=1 after N+1, first pixel (0,0) = buf[0].
- With disp_ready held high, a full frame is 200704 consecutive fires.
- After the fire of the last pixel: disp_valid=0, disp_last=0, busy=0 on the next edge.
- disp_start and the 784th write in the same cycle: the start is ignored, because frame_ready is still 0.

Reset mid-operation:
- Asserting rst_n low forces all outputs to their reset values immediately (asynchronous).
- Buffer contents are undefined after reset.

## Configuration

- MNIST_BINARIZE_EN defined: disp_data = (buffer value >= BIN_THRESH) ? 8'hFF : 8'h00. This is applied at the output register and adds no latency.
- MNIST_BINARIZE_EN undefined: disp_data is the raw buffer value.

## Test plan

- Reset, then disp_start with no frame captured → disp_valid and busy stay 0 for 10 cycles.
- Write 784 pixels with value = index[7:0], strobed every other cycle, then disp_start with disp_ready=1:
  - disp_valid rises 2 cycles after the start.
  - Pixel (h,v) = (28*(v>>4)+(h>>4))[7:0]; for example (16,0)=1 and (0,16)=28.
  - disp_last occurs only at (447,447), after exactly 200704 fires.
- Random disp_ready backpressure (about 50%) during a stream → the output sequence is identical to the no-stall run, and outputs are stable while stalled.
- mnist_start with the same-cycle strobe value 0xAA, followed by 784 strobes with value 0x11 → buf[0]=0x11. A 785th strobe with value 0x77 is ignored, and frame_ready rises after the 784th.
- Assert rst_n low mid-stream at (100,200) → all outputs are 0 immediately and frame_ready is 0. A subsequent disp_start is ignored.
- With MNIST_BINARIZE_EN defined and BIN_THRESH=128, buffer values 127 and 128 → output 0x00 and 0xFF respectively.
